data_acq_scan_core: RTL and testbench
=====================================

DATA_ACQ_SCAN_CORE -- requirements
Module: data_acq_scan_core

Interface
REQ-001 Parameter NUM_CH, 8, number of sensor channels (1..8).
REQ-002 Parameter DATA_W, 16, sensor sample width (1..16).
REQ-003 Parameter FIFO_DEPTH, 8, result FIFO entries (power of two, 2..64).
REQ-004 Clk  in  1  single clock; all state on posedge Clk.
REQ-005 En  in  1  reset; asynchronous, active-low (En low clears all state).
REQ-006 CmdWr  in  1  one-cycle strobe; CPUCommand is sampled when CmdWr=1.
REQ-007 CPUCommand  in  32  [31:30] mode (00 stop, 01 single scan, 10 continuous, 11 invalid); [29:22] channel mask; [21:20] avg_log2 (1/2/4/8 samples); [19:8] timeout threshold in cycles (0 = none); [1] clear sticky flags.
REQ-008 SensorReq  out  NUM_CH  one-hot sample request to the active channel.
REQ-009 SensorValid  in  NUM_CH  per-channel sample-valid strobe.
REQ-010 SensorData  in  NUM_CH x DATA_W  packed per-channel sample data.
REQ-011 ResultPop  in  1  one-cycle strobe; removes the FIFO head.
REQ-012 ResultForCPU  out  32  FIFO head: [31:16] value (zero-extended), [15:13] error (001 ok, 111 timeout), [12:10] channel, [9:1] 0, [0] valid.
REQ-013 StatusBits  out  4  {busy, err_sticky, ovf_sticky, nonempty}.
REQ-014 FifoLevel  out  clog2(FIFO_DEPTH+1)  current entry count.

Function
REQ-015 FSM states SHALL be IDLE, SAMPLE, PUSH; busy SHALL be 1 in SAMPLE and PUSH.
REQ-016 In IDLE, CmdWr with mode 01/10 and mask[NUM_CH-1:0]!=0 SHALL capture the command and enter SAMPLE on the lowest set mask bit.
REQ-017 CmdWr with mode 11, or a run command with an empty mask, SHALL be ignored and set err_sticky.
REQ-018 CmdWr with mode 00 in any state SHALL return to IDLE next cycle, drop the partial accumulation, deassert SensorReq, and keep the FIFO contents.
REQ-019 CmdWr with a run mode while busy SHALL be ignored; CmdWr with bit[1]=1 SHALL clear err_sticky and ovf_sticky in any state.
REQ-020 In SAMPLE, SensorReq SHALL equal one-hot(channel); every cycle with SensorValid[channel]=1 SHALL add SensorData[channel] to a DATA_W+3-bit accumulator and reset the timeout counter.
REQ-021 Once 2^avg_log2 samples are accumulated, the FSM SHALL enter PUSH with value = accumulator >> avg_log2 (truncated), error 001.
REQ-022 If the threshold is nonzero and the cycles without valid reach the threshold, the FSM SHALL enter PUSH with value 0, error 111, and set err_sticky.
REQ-023 PUSH SHALL last one cycle, write the entry if the FIFO is not full, or else drop it and set ovf_sticky.
REQ-024 From PUSH, the FSM SHALL move to the next set mask bit above the current channel; past the highest set bit, single scan SHALL go to IDLE and continuous SHALL wrap to the lowest set bit.
REQ-025 SensorReq SHALL be 0 in PUSH and IDLE; the accumulator, sample count and timeout counter SHALL clear on entering SAMPLE.
REQ-026 Latency: SensorReq SHALL assert the cycle after CmdWr; an entry completed by valid at cycle k SHALL be visible on ResultForCPU at cycle k+2.
REQ-027 The FIFO SHALL be first-word-fall-through; when empty, ResultForCPU SHALL be 0.
REQ-028 ResultPop on an empty FIFO SHALL be ignored.
REQ-029 A push and a pop in the same cycle on a full FIFO SHALL both take effect with no overflow.
REQ-030 A push and a pop in the same cycle on an empty FIFO SHALL store the entry and ignore the pop.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FifoLevel SHALL never exceed FIFO_DEPTH.

Reset
REQ-032 While En=0, the core SHALL enter IDLE and clear the FIFO, counters, sticky flags and captured command.
REQ-033 While En=0, SensorReq, ResultForCPU, StatusBits and FifoLevel SHALL all be 0.
REQ-034 Deasserting En mid-SAMPLE SHALL drop SensorReq asynchronously and push no entry.

Verification
REQ-035 Single scan, mask 0x01, avg_log2 0, valid at cycle 3 with data 0x1234 -> ResultForCPU=0x12342001 from cycle 5; busy=0 afterwards.
REQ-036 Channel 1, avg_log2 2, samples 10,20,30,41 -> entry 0x00192401.
REQ-037 Channel 2, threshold 5, no valid -> after 5 cycles entry 0x0000E801 and err_sticky=1; CmdWr with bit[1]=1 clears err_sticky.
REQ-038 FIFO_DEPTH 4, continuous mode, mask 0x01, no pops -> FifoLevel=4, ovf_sticky=1 on the 5th entry; one pop plus a simultaneous push -> level stays 4.
REQ-039 Mask 0x05 single scan -> entries in order channel 0 then channel 2, then IDLE; a stop command mid-SAMPLE -> SensorReq=0 next cycle, no entry.
REQ-040 En pulled low with 3 entries queued -> FifoLevel=0, ResultForCPU=0, StatusBits=0 immediately.

Source files
------------

// File: rtl/data_acq_scan_core_if.sv
// CPU/sensor-facing bus of the acquisition scan core.
// The core binds to the slave modport; the CPU/sensor side drives through master.
interface data_acq_scan_core_if #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                     CmdWr;
  logic [31:0]              CPUCommand;
  logic [NUM_CH-1:0]        SensorReq;
  logic [NUM_CH-1:0]        SensorValid;
  logic [NUM_CH*DATA_W-1:0] SensorData;
  logic                     ResultPop;
  logic [31:0]              ResultForCPU;
  logic [3:0]               StatusBits;
  logic [LVL_W-1:0]         FifoLevel;

  modport master (
    output CmdWr, CPUCommand, SensorValid, SensorData, ResultPop,
    input  SensorReq, ResultForCPU, StatusBits, FifoLevel
  );

  modport slave (
    input  CmdWr, CPUCommand, SensorValid, SensorData, ResultPop,
    output SensorReq, ResultForCPU, StatusBits, FifoLevel
  );
endinterface

// File: rtl/data_acq_scan_core.sv
// Multi-channel sensor scan engine: sequences through masked channels, averages
// 2^n samples (or times out) per channel and queues results in a FWFT FIFO.
module data_acq_scan_core #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 Clk,
  input  logic                 En,
  data_acq_scan_core_if.slave  bus
);
  localparam int ACC_W = DATA_W + 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, PUSH} state_t;

  state_t state_reg, state_next;

  // Captured command
  logic              cont_reg;
  logic [NUM_CH-1:0] mask_reg;
  logic [1:0]        avg_reg;
  logic [11:0]       thr_reg;
  logic [2:0]        ch_reg;

  // Per-channel accumulation
  logic [ACC_W-1:0]  acc_reg;
  logic [3:0]        cnt_reg;
  logic [11:0]       tcnt_reg;
  logic [DATA_W-1:0] res_value_reg;
  logic [2:0]        res_err_reg;

  logic err_reg, ovf_reg;

  // FIFO
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;

  // Command decode
  logic [1:0]        cmd_mode;
  logic [NUM_CH-1:0] cmd_mask;
  logic              run_cmd, stop_cmd, bad_cmd, clr_cmd, start;
  logic              cmd_unused;

  assign cmd_mode   = bus.CPUCommand[31:30];
  assign cmd_mask   = bus.CPUCommand[22 +: NUM_CH];
  assign run_cmd    = bus.CmdWr && (cmd_mode == 2'b01 || cmd_mode == 2'b10);
  assign stop_cmd   = bus.CmdWr && (cmd_mode == 2'b00);
  assign clr_cmd    = bus.CmdWr && bus.CPUCommand[1];
  assign bad_cmd    = (bus.CmdWr && cmd_mode == 2'b11) || (run_cmd && cmd_mask == '0);
  assign start      = run_cmd && (cmd_mask != '0) && (state_reg == IDLE);
  assign cmd_unused = ^{bus.CPUCommand[29:22], bus.CPUCommand[7:2], bus.CPUCommand[0]};

  function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = i[2:0];
    end
  endfunction

  // Per-channel views: sample slices and mask bits strictly above the active channel
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] above_mask;
  logic              has_above;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]    = bus.SensorData[gi*DATA_W +: DATA_W];
      assign above_mask[gi] = mask_reg[gi] && (3'(gi) > ch_reg);
    end
  endgenerate

  assign has_above = |above_mask;

  logic              valid_sel;
  logic [DATA_W-1:0] data_sel;
  logic [ACC_W-1:0]  acc_sum;
  logic [3:0]        target;
  logic              sample_done, timeout_hit;

  assign valid_sel   = bus.SensorValid[ch_reg];
  assign data_sel    = ch_data[ch_reg];
  assign acc_sum     = acc_reg + ACC_W'(data_sel);
  assign target      = 4'd1 << avg_reg;
  assign sample_done = (state_reg == SAMPLE) && valid_sel && ((cnt_reg + 4'd1) == target);
  assign timeout_hit = (state_reg == SAMPLE) && !valid_sel && (thr_reg != 12'd0) &&
                       ((tcnt_reg + 12'd1) >= thr_reg);

  // FSM: state register
  always_ff @(posedge Clk or negedge En) begin
    if (!En) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state; a stop command overrides everything
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SAMPLE;
      SAMPLE:  if (sample_done || timeout_hit) state_next = PUSH;
      PUSH:    state_next = (has_above || cont_reg) ? SAMPLE : IDLE;
      default: state_next = IDLE;
    endcase
    if (stop_cmd) state_next = IDLE;
  end

  // FSM: outputs
  logic [NUM_CH-1:0] sensor_req;
  logic              busy;

  always_comb begin
    sensor_req = '0;
    busy       = 1'b0;
    case (state_reg)
      SAMPLE: begin
        sensor_req = NUM_CH'(1) << ch_reg;
        busy       = 1'b1;
      end
      PUSH:    busy = 1'b1;
      default: ;
    endcase
  end

  // Command capture, channel sequencing and accumulation
  always_ff @(posedge Clk or negedge En) begin
    if (!En) begin
      cont_reg      <= 1'b0;
      mask_reg      <= '0;
      avg_reg       <= 2'd0;
      thr_reg       <= 12'd0;
      ch_reg        <= 3'd0;
      acc_reg       <= '0;
      cnt_reg       <= 4'd0;
      tcnt_reg      <= 12'd0;
      res_value_reg <= '0;
      res_err_reg   <= 3'd0;
    end else begin
      if (start) begin
        cont_reg <= (cmd_mode == 2'b10);
        mask_reg <= cmd_mask;
        avg_reg  <= bus.CPUCommand[21:20];
        thr_reg  <= bus.CPUCommand[19:8];
        ch_reg   <= lowest_set(cmd_mask);
      end
      if (state_reg == SAMPLE) begin
        if (valid_sel) begin
          acc_reg  <= acc_sum;
          cnt_reg  <= cnt_reg + 4'd1;
          tcnt_reg <= 12'd0;
        end else begin
          tcnt_reg <= tcnt_reg + 12'd1;
        end
        if (sample_done) begin
          res_value_reg <= DATA_W'(acc_sum >> avg_reg);
          res_err_reg   <= 3'b001;
        end else if (timeout_hit) begin
          res_value_reg <= '0;
          res_err_reg   <= 3'b111;
        end
      end
      if (state_reg == PUSH)
        ch_reg <= has_above ? lowest_set(above_mask) : lowest_set(mask_reg);
      // Fresh accumulation every time a channel is (re)entered
      if (state_next == SAMPLE && state_reg != SAMPLE) begin
        acc_reg  <= '0;
        cnt_reg  <= 4'd0;
        tcnt_reg <= 12'd0;
      end
    end
  end

  // FIFO control
  logic        push_req, pop_ok, full, wr_ok, push_drop;
  logic [31:0] entry;

  assign push_req  = (state_reg == PUSH);
  assign pop_ok    = bus.ResultPop && (level_reg != '0);
  assign full      = (level_reg == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_ok     = push_req && (!full || pop_ok);
  assign push_drop = push_req && full && !pop_ok;
  assign entry     = {16'(res_value_reg), res_err_reg, ch_reg, 9'd0, 1'b1};

  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge Clk or negedge En) begin
    if (!En) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_reg + LVL_W'(wr_ok) - LVL_W'(pop_ok);
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge Clk or negedge En) begin
    if (!En) begin
      err_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (clr_cmd) begin
        err_reg <= 1'b0;
        ovf_reg <= 1'b0;
      end
      if (bad_cmd || timeout_hit) err_reg <= 1'b1;
      if (push_drop)              ovf_reg <= 1'b1;
    end
  end

  assign bus.SensorReq    = sensor_req;
  assign bus.ResultForCPU = (level_reg != '0) ? mem[rd_ptr_reg] : 32'd0;
  assign bus.StatusBits   = {busy, err_reg, ovf_reg, level_reg != '0};
  assign bus.FifoLevel    = level_reg;

endmodule

// File: tb/tb_data_acq_scan_core.sv
// Scenario bench for data_acq_scan_core: expected FIFO entries are queued as
// stimulus is driven and compared against the FIFO head as entries are popped.
module tb_data_acq_scan_core;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic Clk = 1'b0;
  logic En  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  data_acq_scan_core_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

  data_acq_scan_core #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .Clk (Clk),
    .En  (En),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] mk_cmd(input logic [1:0] mode, input logic [7:0] mask,
                                         input logic [1:0] avg, input logic [11:0] thr,
                                         input logic clr);
    return {mode, mask, avg, thr, 6'd0, clr, 1'b0};
  endfunction

  function automatic logic [31:0] mk_entry(input logic [15:0] v, input logic [2:0] e,
                                           input logic [2:0] ch);
    return {v, e, ch, 9'd0, 1'b1};
  endfunction

  task automatic send_cmd(input logic [31:0] c);
    bus.CmdWr      = 1'b1;
    bus.CPUCommand = c;
    tick();
    bus.CmdWr      = 1'b0;
    bus.CPUCommand = '0;
  endtask

  task automatic send_sample(input int ch, input logic [15:0] d);
    bus.SensorValid               = 8'(1) << ch;
    bus.SensorData                = '0;
    bus.SensorData[ch*16 +: 16]   = d;
    tick();
    bus.SensorValid = '0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (bus.FifoLevel != 0 && guard < 20) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_extra got=%h required=none", tag, bus.ResultForCPU);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.ResultForCPU !== exp_w) begin
          failures++;
          $display("FAIL %s_entry got=%h required=%h", tag, bus.ResultForCPU, exp_w);
        end
      end
      bus.ResultPop = 1'b1;
      tick();
      bus.ResultPop = 1'b0;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.ResultForCPU !== 32'd0) begin
      failures++;
      $display("FAIL %s_missing left=%0d head=%h required_left=0 head=0", tag, exp_q.size(),
               bus.ResultForCPU);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.CmdWr = 0; bus.CPUCommand = '0; bus.SensorValid = '0; bus.SensorData = '0;
    bus.ResultPop = 0;
    En = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.SensorReq !== 8'h00 || bus.ResultForCPU !== 32'd0 ||
        bus.StatusBits !== 4'h0 || bus.FifoLevel !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%h/%h required=0/0/0/0", bus.SensorReq,
               bus.ResultForCPU, bus.StatusBits, bus.FifoLevel);
    end
    En = 1'b1;
    tick();
    checks++;
    if (bus.StatusBits !== 4'h0 || bus.SensorReq !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle got=%h/%h required=0/0", bus.StatusBits, bus.SensorReq);
    end
  endtask

  task automatic test_single();
    send_cmd(mk_cmd(2'b01, 8'h01, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.SensorReq !== 8'h01 || bus.StatusBits[3] !== 1'b1) begin
      failures++;
      $display("FAIL single_req got=%h busy=%b required=01 busy=1", bus.SensorReq, bus.StatusBits[3]);
    end
    tick();
    exp_q.push_back(mk_entry(16'h1234, 3'b001, 3'd0));
    send_sample(0, 16'h1234);
    checks++;
    if (bus.ResultForCPU !== 32'd0 || bus.SensorReq !== 8'h00) begin
      failures++;
      $display("FAIL single_early got=%h req=%h required=0 req=0", bus.ResultForCPU, bus.SensorReq);
    end
    tick();
    checks++;
    if (bus.ResultForCPU !== exp_q[0] || bus.StatusBits[3] !== 1'b0) begin
      failures++;
      $display("FAIL single_latency got=%h busy=%b required=%h busy=0", bus.ResultForCPU,
               bus.StatusBits[3], exp_q[0]);
    end
    drain("single");
  endtask

  task automatic test_average();
    send_cmd(mk_cmd(2'b01, 8'h02, 2'd2, 12'd0, 1'b0));
    checks++;
    if (bus.SensorReq !== 8'h02) begin
      failures++;
      $display("FAIL avg_req got=%h required=02", bus.SensorReq);
    end
    send_sample(0, 16'hFFFF);
    send_sample(1, 16'd10);
    tick();
    send_sample(1, 16'd20);
    send_sample(1, 16'd30);
    checks++;
    if (bus.SensorReq !== 8'h02 || bus.FifoLevel !== 3'd0) begin
      failures++;
      $display("FAIL avg_partial got=%h lvl=%0d required=02 lvl=0", bus.SensorReq, bus.FifoLevel);
    end
    exp_q.push_back(mk_entry(16'h0019, 3'b001, 3'd1));
    send_sample(1, 16'd41);
    tick();
    checks++;
    if (bus.ResultForCPU !== exp_q[0]) begin
      failures++;
      $display("FAIL avg_entry got=%h required=%h", bus.ResultForCPU, exp_q[0]);
    end
    drain("avg");
  endtask

  task automatic test_timeout();
    send_cmd(mk_cmd(2'b01, 8'h04, 2'd0, 12'd5, 1'b0));
    exp_q.push_back(mk_entry(16'h0000, 3'b111, 3'd2));
    tick(); tick(); tick(); tick();
    checks++;
    if (bus.SensorReq !== 8'h04) begin
      failures++;
      $display("FAIL tmo_still_sampling got=%h required=04", bus.SensorReq);
    end
    tick();
    checks++;
    if (bus.SensorReq !== 8'h00 || bus.StatusBits[2] !== 1'b1) begin
      failures++;
      $display("FAIL tmo_push got=%h err=%b required=00 err=1", bus.SensorReq, bus.StatusBits[2]);
    end
    tick();
    checks++;
    if (bus.ResultForCPU !== exp_q[0]) begin
      failures++;
      $display("FAIL tmo_entry got=%h required=%h", bus.ResultForCPU, exp_q[0]);
    end
    send_cmd(mk_cmd(2'b00, 8'h00, 2'd0, 12'd0, 1'b1));
    checks++;
    if (bus.StatusBits[2] !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got=%b required=0", bus.StatusBits[2]);
    end
    drain("tmo");
  endtask

  task automatic test_invalid();
    send_cmd(mk_cmd(2'b11, 8'h01, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.StatusBits !== 4'b0100 || bus.SensorReq !== 8'h00) begin
      failures++;
      $display("FAIL inv_mode got=%b req=%h required=0100 req=00", bus.StatusBits, bus.SensorReq);
    end
    send_cmd(mk_cmd(2'b00, 8'h00, 2'd0, 12'd0, 1'b1));
    send_cmd(mk_cmd(2'b01, 8'h00, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.StatusBits !== 4'b0100) begin
      failures++;
      $display("FAIL inv_mask got=%b required=0100", bus.StatusBits);
    end
    send_cmd(mk_cmd(2'b00, 8'h00, 2'd0, 12'd0, 1'b1));
  endtask

  task automatic test_overflow();
    send_cmd(mk_cmd(2'b10, 8'h01, 2'd0, 12'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(mk_entry(16'h0100 + 16'(i), 3'b001, 3'd0));
      send_sample(0, 16'h0100 + 16'(i));
      tick();
      if (i == 3) begin
        checks++;
        if (bus.FifoLevel !== 3'd4 || bus.StatusBits[1] !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full got=%0d ovf=%b required=4 ovf=0", bus.FifoLevel, bus.StatusBits[1]);
        end
      end
    end
    checks++;
    if (bus.FifoLevel !== 3'd4 || bus.StatusBits[1] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop got=%0d ovf=%b required=4 ovf=1", bus.FifoLevel, bus.StatusBits[1]);
    end
    send_cmd(mk_cmd(2'b10, 8'h01, 2'd0, 12'd0, 1'b1));
    checks++;
    if (bus.StatusBits[1] !== 1'b0 || bus.StatusBits[3] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear got=%b required=1x0x", bus.StatusBits);
    end
    send_sample(0, 16'h0200);
    exp_w = exp_q.pop_front();
    checks++;
    if (bus.ResultForCPU !== exp_w) begin
      failures++;
      $display("FAIL ovf_head got=%h required=%h", bus.ResultForCPU, exp_w);
    end
    exp_q.push_back(mk_entry(16'h0200, 3'b001, 3'd0));
    bus.ResultPop = 1'b1;
    tick();
    bus.ResultPop = 1'b0;
    checks++;
    if (bus.FifoLevel !== 3'd4 || bus.StatusBits[1] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pushpop got=%0d ovf=%b required=4 ovf=0", bus.FifoLevel, bus.StatusBits[1]);
    end
    send_cmd(mk_cmd(2'b00, 8'h00, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.StatusBits[3] !== 1'b0 || bus.SensorReq !== 8'h00) begin
      failures++;
      $display("FAIL ovf_stop got=%b req=%h required=busy0 req=00", bus.StatusBits, bus.SensorReq);
    end
    drain("ovf");
  endtask

  task automatic test_back_to_back();
    send_cmd(mk_cmd(2'b01, 8'h05, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.SensorReq !== 8'h01) begin
      failures++;
      $display("FAIL scan_first got=%h required=01", bus.SensorReq);
    end
    exp_q.push_back(mk_entry(16'hAAAA, 3'b001, 3'd0));
    send_sample(0, 16'hAAAA);
    tick();
    checks++;
    if (bus.SensorReq !== 8'h04) begin
      failures++;
      $display("FAIL scan_next got=%h required=04", bus.SensorReq);
    end
    exp_q.push_back(mk_entry(16'hBBBB, 3'b001, 3'd2));
    send_sample(2, 16'hBBBB);
    tick();
    checks++;
    if (bus.StatusBits[3] !== 1'b0 || bus.FifoLevel !== 3'd2) begin
      failures++;
      $display("FAIL scan_end busy=%b lvl=%0d required=busy0 lvl=2", bus.StatusBits[3], bus.FifoLevel);
    end
    drain("scan");
  endtask

  task automatic test_stop();
    send_cmd(mk_cmd(2'b01, 8'h08, 2'd1, 12'd0, 1'b0));
    checks++;
    if (bus.SensorReq !== 8'h08) begin
      failures++;
      $display("FAIL stop_req got=%h required=08", bus.SensorReq);
    end
    send_sample(3, 16'd999);
    send_cmd(mk_cmd(2'b00, 8'h00, 2'd0, 12'd0, 1'b0));
    checks++;
    if (bus.SensorReq !== 8'h00 || bus.StatusBits[3] !== 1'b0 || bus.FifoLevel !== 3'd0) begin
      failures++;
      $display("FAIL stop_idle got=%h st=%b lvl=%0d required=00 busy0 lvl=0", bus.SensorReq,
               bus.StatusBits, bus.FifoLevel);
    end
    send_cmd(mk_cmd(2'b01, 8'h08, 2'd1, 12'd0, 1'b0));
    send_sample(3, 16'd100);
    exp_q.push_back(mk_entry(16'd150, 3'b001, 3'd3));
    send_sample(3, 16'd200);
    tick();
    checks++;
    if (bus.ResultForCPU !== exp_q[0]) begin
      failures++;
      $display("FAIL stop_restart got=%h required=%h", bus.ResultForCPU, exp_q[0]);
    end
    drain("stop");
  endtask

  task automatic test_reset_midscan();
    send_cmd(mk_cmd(2'b10, 8'h01, 2'd0, 12'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_entry(16'h0300 + 16'(i), 3'b001, 3'd0));
      send_sample(0, 16'h0300 + 16'(i));
      tick();
    end
    checks++;
    if (bus.FifoLevel !== 3'd3 || bus.SensorReq !== 8'h01) begin
      failures++;
      $display("FAIL rst_pre lvl=%0d req=%h required=3 req=01", bus.FifoLevel, bus.SensorReq);
    end
    #2 En = 1'b0;
    #1;
    checks++;
    if (bus.SensorReq !== 8'h00 || bus.ResultForCPU !== 32'd0 ||
        bus.StatusBits !== 4'h0 || bus.FifoLevel !== 3'd0) begin
      failures++;
      $display("FAIL rst_async got=%h/%h/%h/%h required=0/0/0/0", bus.SensorReq,
               bus.ResultForCPU, bus.StatusBits, bus.FifoLevel);
    end
    exp_q.delete();
    tick();
    En = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.FifoLevel !== 3'd0 || bus.StatusBits !== 4'h0) begin
      failures++;
      $display("FAIL rst_after lvl=%0d st=%b required=0 0000", bus.FifoLevel, bus.StatusBits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_timeout();
    test_invalid();
    test_overflow();
    test_back_to_back();
    test_stop();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
